// File: rtl/traffic_phase_scheduler.sv
// ============================================================================
// Module   : traffic_phase_scheduler
// Brief    : Four-approach round-robin traffic light phase scheduler with
//            min/max green, yellow and all-red clearance timing. The optional
//            emergency preemption is built when EMERG_PREEMPT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_scheduler #(
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 10,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
`ifdef EMERG_PREEMPT_EN
  input  logic [3:0] emerg_req,
  output logic       preempt_active,
`endif
  output logic [2:0] light_N,
  output logic [2:0] light_E,
  output logic [2:0] light_S,
  output logic [2:0] light_W,
  output logic [1:0] active_dir,
  output logic [3:0] phase_timer
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_t;

  localparam logic [3:0] c_MIN_LAST    = 4'(MIN_GREEN - 1);
  localparam logic [3:0] c_MAX_LAST    = 4'(MAX_GREEN - 1);
  localparam logic [3:0] c_YELLOW_LAST = 4'(YELLOW_TIME - 1);
  localparam logic [3:0] c_ALLRED_LAST = 4'(ALLRED_TIME - 1);
  localparam logic [2:0] c_RED         = 3'b100;
  localparam logic [2:0] c_YELLOW      = 3'b010;
  localparam logic [2:0] c_GREEN       = 3'b001;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_dir;
  logic [1:0] w_next_dir;
  logic [3:0] r_timer;
  logic [1:0] r_rr_ptr;
  logic [3:0] w_emerg;
  logic [3:0] w_own_mask;
  logic       w_others_req;
  logic [2:0] w_lights [4];

`ifdef EMERG_PREEMPT_EN
  logic r_preempt;

  assign w_emerg        = emerg_req;
  assign preempt_active = r_preempt;

  always_ff @(posedge clk) begin
    if (rst) r_preempt <= 1'b0;
    else     r_preempt <= |emerg_req;
  end
`else
  assign w_emerg = 4'b0000;
`endif

  // First set request scanning ptr, ptr+1, ... (mod 4).
  function automatic logic [1:0] f_rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    f_rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) f_rr_pick = idx;
    end
  endfunction

  function automatic logic [1:0] f_low_pick(input logic [3:0] e);
    f_low_pick = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (e[k]) f_low_pick = 2'(k);
    end
  endfunction

  assign w_own_mask   = 4'b0001 << r_dir;
  assign w_others_req = |(req & ~w_own_mask);

  always_comb begin
    w_next_state = r_state;
    w_next_dir   = r_dir;
    case (r_state)
      S_IDLE: begin
        if (|w_emerg) begin
          w_next_state = S_GREEN;
          w_next_dir   = f_low_pick(w_emerg);
        end else if (|req) begin
          w_next_state = S_GREEN;
          w_next_dir   = f_rr_pick(req, r_rr_ptr);
        end
      end
      S_GREEN: begin
        if (|w_emerg) begin
          if (!w_emerg[r_dir]) w_next_state = S_YELLOW;
        end else if ((r_timer >= c_MIN_LAST && !req[r_dir]) ||
                     (r_timer >= c_MAX_LAST && w_others_req)) begin
          w_next_state = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (r_timer == c_YELLOW_LAST) w_next_state = S_ALLRED;
      end
      S_ALLRED: begin
        if (r_timer == c_ALLRED_LAST) begin
          if (|w_emerg) begin
            w_next_state = S_GREEN;
            w_next_dir   = f_low_pick(w_emerg);
          end else if (|req) begin
            w_next_state = S_GREEN;
            w_next_dir   = f_rr_pick(req, r_rr_ptr);
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Green timer saturates so a held approach never wraps the 4-bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_dir    <= 2'd0;
      r_timer  <= 4'd0;
      r_rr_ptr <= 2'd0;
    end else begin
      r_state <= w_next_state;
      r_dir   <= w_next_dir;
      if (w_next_state != r_state || r_state == S_IDLE)
        r_timer <= 4'd0;
      else if (!(r_state == S_GREEN && r_timer >= c_MAX_LAST))
        r_timer <= r_timer + 4'd1;
      if (r_state == S_YELLOW && w_next_state == S_ALLRED)
        r_rr_ptr <= r_dir + 2'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) w_lights[k] = c_RED;
    if (r_state == S_GREEN)  w_lights[r_dir] = c_GREEN;
    if (r_state == S_YELLOW) w_lights[r_dir] = c_YELLOW;
  end

  assign light_N     = w_lights[0];
  assign light_E     = w_lights[1];
  assign light_S     = w_lights[2];
  assign light_W     = w_lights[3];
  assign active_dir  = r_dir;
  assign phase_timer = r_timer;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
// ============================================================================
// Module   : tb_traffic_phase_scheduler
// Brief    : Directed self-checking bench for traffic_phase_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [2:0] light_N, light_E, light_S, light_W;
  logic [1:0] active_dir;
  logic [3:0] phase_timer;
`ifdef EMERG_PREEMPT_EN
  logic [3:0] emerg_req;
  logic       preempt_active;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int PH_RED    = 0;
  localparam int PH_GREEN  = 1;
  localparam int PH_YELLOW = 2;

  traffic_phase_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
`ifdef EMERG_PREEMPT_EN
    .emerg_req     (emerg_req),
    .preempt_active(preempt_active),
`endif
    .light_N     (light_N),
    .light_E     (light_E),
    .light_S     (light_S),
    .light_W     (light_W),
    .active_dir  (active_dir),
    .phase_timer (phase_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {N,E,S,W} light word for a phase on approach d.
  function automatic logic [11:0] exp_lights(input int ph, input int d);
    logic [11:0] v;
    v = 12'h924;
    if (ph == PH_GREEN)  v[11-3*d -: 3] = 3'b001;
    if (ph == PH_YELLOW) v[11-3*d -: 3] = 3'b010;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
`ifdef EMERG_PREEMPT_EN
    emerg_req = 4'b0000;
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
`ifdef EMERG_PREEMPT_EN
    emerg_req = 4'b0000;
`endif
    tick();
    tick();
    n_cmp++;
    if ({light_N, light_E, light_S, light_W} !== 12'h924) begin
      n_fail++;
      $display("FAIL reset_lights: got %h want %h", {light_N, light_E, light_S, light_W}, 12'h924);
    end
    n_cmp++;
    if ({active_dir, phase_timer} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_dir_timer: got dir=%0d timer=%0d want 0/0", active_dir, phase_timer);
    end
`ifdef EMERG_PREEMPT_EN
    n_cmp++;
    if (preempt_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_preempt: got %b want 0", preempt_active);
    end
`endif
    rst = 1'b0;
    req = 4'b0000;
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if ({light_N, light_E, light_S, light_W, active_dir, phase_timer} !== {12'h924, 2'd0, 4'd0}) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got lights=%h dir=%0d timer=%0d want 924/0/0",
                 i, {light_N, light_E, light_S, light_W}, active_dir, phase_timer);
      end
    end
  endtask

  task automatic test_single_pulse();
    int ph;
    int tm;
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      if (i < 4)      begin ph = PH_GREEN;  tm = i;     end
      else if (i < 6) begin ph = PH_YELLOW; tm = i - 4; end
      else            begin ph = PH_RED;    tm = 0;     end
      n_cmp++;
      if ({light_N, light_E, light_S, light_W, active_dir, phase_timer} !==
          {exp_lights(ph, 0), 2'd0, 4'(tm)}) begin
        n_fail++;
        $display("FAIL pulse_cycle%0d: got lights=%h dir=%0d timer=%0d want %h/0/%0d",
                 i, {light_N, light_E, light_S, light_W}, active_dir, phase_timer,
                 exp_lights(ph, 0), tm);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int ph;
    int tm;
    int d;
    int pos;
    do_reset();
    req = 4'b1111;
    tick();
    for (int c = 0; c < 53; c++) begin
      d   = (c / 13) % 4;
      pos = c % 13;
      if (pos < 10)      begin ph = PH_GREEN;  tm = pos;      end
      else if (pos < 12) begin ph = PH_YELLOW; tm = pos - 10; end
      else               begin ph = PH_RED;    tm = 0;        end
      n_cmp++;
      if ({light_N, light_E, light_S, light_W, phase_timer} !== {exp_lights(ph, d), 4'(tm)}) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got lights=%h timer=%0d want %h/%0d",
                 c, {light_N, light_E, light_S, light_W}, phase_timer, exp_lights(ph, d), tm);
      end
      if (ph != PH_RED) begin
        n_cmp++;
        if (active_dir !== 2'(d)) begin
          n_fail++;
          $display("FAIL rr_dir_cycle%0d: got %0d want %0d", c, active_dir, d);
        end
      end
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_hold_then_other();
    int tm;
    do_reset();
    req = 4'b0001;
    tick();
    for (int i = 0; i < 15; i++) begin
      tm = (i < 9) ? i : 9;
      n_cmp++;
      if ({light_N, light_E, light_S, light_W, active_dir, phase_timer} !==
          {exp_lights(PH_GREEN, 0), 2'd0, 4'(tm)}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got lights=%h dir=%0d timer=%0d want %h/0/%0d",
                 i, {light_N, light_E, light_S, light_W}, active_dir, phase_timer,
                 exp_lights(PH_GREEN, 0), tm);
      end
      tick();
    end
    req = 4'b0011;
    tick();
    n_cmp++;
    if ({light_N, light_E, light_S, light_W, phase_timer} !== {exp_lights(PH_YELLOW, 0), 4'd0}) begin
      n_fail++;
      $display("FAIL hold_yellow: got lights=%h timer=%0d want %h/0",
               {light_N, light_E, light_S, light_W}, phase_timer, exp_lights(PH_YELLOW, 0));
    end
    tick();
    tick();
    n_cmp++;
    if ({light_N, light_E, light_S, light_W} !== 12'h924) begin
      n_fail++;
      $display("FAIL hold_allred: got %h want 924", {light_N, light_E, light_S, light_W});
    end
    tick();
    n_cmp++;
    if ({light_N, light_E, light_S, light_W, active_dir, phase_timer} !==
        {exp_lights(PH_GREEN, 1), 2'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL hold_east_green: got lights=%h dir=%0d timer=%0d want %h/1/0",
               {light_N, light_E, light_S, light_W}, active_dir, phase_timer, exp_lights(PH_GREEN, 1));
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_midphase();
    do_reset();
    // South cycle through to IDLE leaves the round-robin pointer at W.
    req = 4'b0100;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 8; i++) tick();
    req = 4'b0100;
    tick();
    n_cmp++;
    if ({light_N, light_E, light_S, light_W, active_dir} !== {exp_lights(PH_GREEN, 2), 2'd2}) begin
      n_fail++;
      $display("FAIL mid_south_green: got lights=%h dir=%0d want %h/2",
               {light_N, light_E, light_S, light_W}, active_dir, exp_lights(PH_GREEN, 2));
    end
    req = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if ({light_N, light_E, light_S, light_W} !== exp_lights(PH_YELLOW, 2)) begin
      n_fail++;
      $display("FAIL mid_south_yellow: got %h want %h",
               {light_N, light_E, light_S, light_W}, exp_lights(PH_YELLOW, 2));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({light_N, light_E, light_S, light_W, active_dir, phase_timer} !== {12'h924, 2'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: got lights=%h dir=%0d timer=%0d want 924/0/0",
               {light_N, light_E, light_S, light_W}, active_dir, phase_timer);
    end
    req = 4'b1111;
    tick();
    n_cmp++;
    if ({light_N, light_E, light_S, light_W, active_dir, phase_timer} !==
        {exp_lights(PH_GREEN, 0), 2'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL mid_rrptr_north: got lights=%h dir=%0d timer=%0d want %h/0/0",
               {light_N, light_E, light_S, light_W}, active_dir, phase_timer, exp_lights(PH_GREEN, 0));
    end
    req = 4'b0000;
  endtask

`ifdef EMERG_PREEMPT_EN
  task automatic test_emergency();
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    n_cmp++;
    if ({light_N, light_E, light_S, light_W, phase_timer} !== {exp_lights(PH_GREEN, 1), 4'd1}) begin
      n_fail++;
      $display("FAIL em_east_green: got lights=%h timer=%0d want %h/1",
               {light_N, light_E, light_S, light_W}, phase_timer, exp_lights(PH_GREEN, 1));
    end
    emerg_req = 4'b0100;
    tick();
    n_cmp++;
    if ({light_N, light_E, light_S, light_W, preempt_active} !== {exp_lights(PH_YELLOW, 1), 1'b1}) begin
      n_fail++;
      $display("FAIL em_east_yellow: got lights=%h preempt=%b want %h/1",
               {light_N, light_E, light_S, light_W}, preempt_active, exp_lights(PH_YELLOW, 1));
    end
    tick();
    tick();
    n_cmp++;
    if ({light_N, light_E, light_S, light_W} !== 12'h924) begin
      n_fail++;
      $display("FAIL em_allred: got %h want 924", {light_N, light_E, light_S, light_W});
    end
    tick();
    n_cmp++;
    if ({light_N, light_E, light_S, light_W, active_dir, preempt_active} !==
        {exp_lights(PH_GREEN, 2), 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL em_south_green: got lights=%h dir=%0d preempt=%b want %h/2/1",
               {light_N, light_E, light_S, light_W}, active_dir, preempt_active, exp_lights(PH_GREEN, 2));
    end
    emerg_req = 4'b0000;
    tick();
    n_cmp++;
    if (preempt_active !== 1'b0) begin
      n_fail++;
      $display("FAIL em_preempt_clear: got %b want 0", preempt_active);
    end
    req = 4'b0000;
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = 4'b0000;
`ifdef EMERG_PREEMPT_EN
    emerg_req = 4'b0000;
`endif
    test_reset();
    test_idle();
    test_single_pulse();
    test_round_robin();
    test_hold_then_other();
    test_reset_midphase();
`ifdef EMERG_PREEMPT_EN
    test_emergency();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
